// File: rtl/coin_pkg.sv
// Shared types and constants for the coin acceptor: coin encoding, coin values
// and the controller state enum.
package coin_pkg;

  typedef enum logic [1:0] {
    COIN_NICKEL  = 2'b00,
    COIN_DIME    = 2'b01,
    COIN_QUARTER = 2'b10,
    COIN_SLUG    = 2'b11
  } coin_type_e;

  localparam logic [7:0] NICKEL_VALUE   = 8'd5;
  localparam logic [7:0] DIME_VALUE     = 8'd10;
  localparam logic [7:0] TWO_DIME_VALUE = 8'd20;
  localparam logic [7:0] QUARTER_VALUE  = 8'd25;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    VEND    = 2'b10,
    CHANGE  = 2'b11
  } state_e;

  // A slug is worth nothing; callers reject it before the value matters.
  function automatic logic [7:0] coin_value(input coin_type_e kind);
    case (kind)
      COIN_NICKEL:  return NICKEL_VALUE;
      COIN_DIME:    return DIME_VALUE;
      COIN_QUARTER: return QUARTER_VALUE;
      default:      return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/change_gen.sv
// Greedy change sequencer: loads the credit to refund and emits one dispenser
// pulse every other cycle (20, then 10, then 5) until nothing is left.
module change_gen
  import coin_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       run,
  input  logic [7:0] load_credit,
  output logic       nickel_out,
  output logic       dime_out,
  output logic       two_dime_out,
  output logic [7:0] remaining,
  output logic       done
);

  logic [7:0] remaining_reg;
  logic       pulse_phase_reg;
  logic       nickel_reg;
  logic       dime_reg;
  logic       two_dime_reg;

  logic [7:0] src_credit;
  logic [7:0] step_value;
  logic       give_two_dime;
  logic       give_dime;
  logic       give_nickel;

  // The first pulse is computed from load_credit so it appears on the very
  // first cycle the controller spends in CHANGE.
  always_comb begin
    src_credit    = load ? load_credit : remaining_reg;
    give_two_dime = 1'b0;
    give_dime     = 1'b0;
    give_nickel   = 1'b0;
    step_value    = 8'd0;
    if (src_credit >= TWO_DIME_VALUE) begin
      give_two_dime = 1'b1;
      step_value    = TWO_DIME_VALUE;
    end else if (src_credit >= DIME_VALUE) begin
      give_dime  = 1'b1;
      step_value = DIME_VALUE;
    end else if (src_credit >= NICKEL_VALUE) begin
      give_nickel = 1'b1;
      step_value  = NICKEL_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      remaining_reg   <= 8'd0;
      pulse_phase_reg <= 1'b0;
      nickel_reg      <= 1'b0;
      dime_reg        <= 1'b0;
      two_dime_reg    <= 1'b0;
    end else if (load || (run && !pulse_phase_reg && remaining_reg != 8'd0)) begin
      remaining_reg   <= src_credit - step_value;
      pulse_phase_reg <= 1'b1;
      nickel_reg      <= give_nickel;
      dime_reg        <= give_dime;
      two_dime_reg    <= give_two_dime;
    end else begin
      pulse_phase_reg <= 1'b0;
      nickel_reg      <= 1'b0;
      dime_reg        <= 1'b0;
      two_dime_reg    <= 1'b0;
    end
  end

  assign nickel_out   = nickel_reg;
  assign dime_out     = dime_reg;
  assign two_dime_out = two_dime_reg;
  assign remaining    = remaining_reg;
  // Done while the pulse that emptied the credit is on the wire.
  assign done         = pulse_phase_reg && (remaining_reg == 8'd0);

endmodule

// File: rtl/coin_acceptor.sv
// Vending coin acceptor: accumulates credit, vends at PRICE, refunds change
// through change_gen and keeps saturating nickel/dime stock counts.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter logic [7:0] PRICE      = 8'd65,
  parameter logic [7:0] CREDIT_MAX = 8'd250
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       vend_req,
  input  logic       coin_return,
  output logic       coin_accept,
  output logic       coin_reject,
  output logic [7:0] credit,
  output logic       vend_go,
  output logic       nickel_out,
  output logic       dime_out,
  output logic       two_dime_out,
  output logic       busy,
  output logic [7:0] nickel_stock,
  output logic [7:0] dime_stock
);

  state_e     state_reg;
  logic [7:0] credit_reg;
  logic [7:0] nickel_stock_reg;
  logic [7:0] dime_stock_reg;
  logic       accept_reg;
  logic       reject_reg;
  logic       vend_go_reg;
  logic       busy_reg;

  coin_type_e coin_kind;
  logic [7:0] coin_val;
  logic [8:0] coin_sum;
  logic       coin_ok;
  logic       take_return;
  logic       take_vend;
  logic       take_coin;
  logic       chg_load;
  logic       chg_done;
  logic [7:0] chg_remaining;

  // Priority: refund beats vend beats coin; a coin that loses is rejected.
  always_comb begin
    coin_kind   = coin_type_e'(coin_type);
    coin_val    = coin_value(coin_kind);
    coin_sum    = {1'b0, credit_reg} + {1'b0, coin_val};
    coin_ok     = (coin_kind != COIN_SLUG) && (coin_sum <= {1'b0, CREDIT_MAX});
    take_return = (state_reg == COLLECT) && coin_return && (credit_reg != 8'd0);
    take_vend   = (state_reg == COLLECT) && !take_return && vend_req &&
                  (credit_reg >= PRICE);
    take_coin   = ((state_reg == IDLE) || (state_reg == COLLECT)) && coin_valid &&
                  coin_ok && !take_return && !take_vend;
    chg_load    = take_return || ((state_reg == VEND) && (credit_reg != 8'd0));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      credit_reg       <= 8'd0;
      nickel_stock_reg <= 8'd0;
      dime_stock_reg   <= 8'd0;
      accept_reg       <= 1'b0;
      reject_reg       <= 1'b0;
      vend_go_reg      <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      accept_reg  <= take_coin;
      reject_reg  <= coin_valid && !take_coin;
      vend_go_reg <= 1'b0;

      if (take_coin && coin_kind == COIN_NICKEL && nickel_stock_reg != 8'hFF)
        nickel_stock_reg <= nickel_stock_reg + 8'd1;
      if (take_coin && coin_kind == COIN_DIME && dime_stock_reg != 8'hFF)
        dime_stock_reg <= dime_stock_reg + 8'd1;

      case (state_reg)
        IDLE, COLLECT: begin
          if (take_return) begin
            // Remaining credit now lives in change_gen until it is paid out.
            state_reg  <= CHANGE;
            busy_reg   <= 1'b1;
            credit_reg <= 8'd0;
          end else if (take_vend) begin
            state_reg   <= VEND;
            busy_reg    <= 1'b1;
            vend_go_reg <= 1'b1;
            credit_reg  <= credit_reg - PRICE;
          end else if (take_coin) begin
            state_reg  <= COLLECT;
            credit_reg <= coin_sum[7:0];
          end
        end
        VEND: begin
          if (credit_reg != 8'd0) begin
            state_reg  <= CHANGE;
            busy_reg   <= 1'b1;
            credit_reg <= 8'd0;
          end else begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        CHANGE: begin
          if (chg_done) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  change_gen u_change_gen (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (chg_load),
    .run          (state_reg == CHANGE),
    .load_credit  (credit_reg),
    .nickel_out   (nickel_out),
    .dime_out     (dime_out),
    .two_dime_out (two_dime_out),
    .remaining    (chg_remaining),
    .done         (chg_done)
  );

  assign credit       = (state_reg == CHANGE) ? chg_remaining : credit_reg;
  assign coin_accept  = accept_reg;
  assign coin_reject  = reject_reg;
  assign vend_go      = vend_go_reg;
  assign busy         = busy_reg;
  assign nickel_stock = nickel_stock_reg;
  assign dime_stock   = dime_stock_reg;

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: hand-computed credit, pulse and stock
// values for rejection, vend, refund, overflow, priority, reset and saturation.
module tb_coin_acceptor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       vend_req = 1'b0;
  logic       coin_return = 1'b0;
  logic       coin_accept;
  logic       coin_reject;
  logic [7:0] credit;
  logic       vend_go;
  logic       nickel_out;
  logic       dime_out;
  logic       two_dime_out;
  logic       busy;
  logic [7:0] nickel_stock;
  logic [7:0] dime_stock;

  int assert_count = 0;
  int fail_count   = 0;

  localparam logic [1:0] NICKEL  = 2'b00;
  localparam logic [1:0] DIME    = 2'b01;
  localparam logic [1:0] QUARTER = 2'b10;
  localparam logic [1:0] SLUG    = 2'b11;

  coin_acceptor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .vend_req     (vend_req),
    .coin_return  (coin_return),
    .coin_accept  (coin_accept),
    .coin_reject  (coin_reject),
    .credit       (credit),
    .vend_go      (vend_go),
    .nickel_out   (nickel_out),
    .dime_out     (dime_out),
    .two_dime_out (two_dime_out),
    .busy         (busy),
    .nickel_stock (nickel_stock),
    .dime_stock   (dime_stock)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assert_count++;
    if (got !== exp) begin
      fail_count++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    coin_valid  = 1'b0;
    vend_req    = 1'b0;
    coin_return = 1'b0;
  endtask

  task automatic insert(input logic [1:0] kind);
    coin_valid = 1'b1;
    coin_type  = kind;
    step();
    $display("coin type=%0d accept=%0b reject=%0b credit=%0d", kind, coin_accept, coin_reject, credit);
  endtask

  task automatic vend();
    vend_req = 1'b1;
    step();
    $display("vend_req vend_go=%0b credit=%0d busy=%0b", vend_go, credit, busy);
  endtask

  task automatic refund();
    coin_return = 1'b1;
    step();
    $display("coin_return busy=%0b credit=%0d", busy, credit);
  endtask

  // Follows a busy period from the current cycle, counting change pulses and
  // checking spacing, exclusivity, exit timing and the final credit.
  task automatic run_change(input string tag, input int exp_first, input int exp_two,
                            input int exp_dime, input int exp_nickel);
    int n_two, n_dime, n_nick, first, last, bad_gap, multi, vend_extra, cyc, hits;
    n_two = 0; n_dime = 0; n_nick = 0; first = -1; last = -100;
    bad_gap = 0; multi = 0; vend_extra = 0; cyc = 0;
    while (busy && cyc < 100) begin
      hits = int'(two_dime_out) + int'(dime_out) + int'(nickel_out);
      if (hits > 1) multi++;
      if (hits > 0) begin
        if (first < 0) first = cyc;
        if (last >= 0 && cyc - last != 2) bad_gap++;
        last = cyc;
      end
      if (cyc > 0 && vend_go) vend_extra++;
      n_two  += int'(two_dime_out);
      n_dime += int'(dime_out);
      n_nick += int'(nickel_out);
      step();
      cyc++;
    end
    $display("change %s two_dime=%0d dime=%0d nickel=%0d cycles=%0d credit=%0d",
             tag, n_two, n_dime, n_nick, cyc, credit);
    check({tag, "_timeout"}, busy, 0);
    check({tag, "_first_pulse"}, first, exp_first);
    check({tag, "_two_dime"}, n_two, exp_two);
    check({tag, "_dime"}, n_dime, exp_dime);
    check({tag, "_nickel"}, n_nick, exp_nickel);
    check({tag, "_one_hot"}, multi, 0);
    check({tag, "_alternate"}, bad_gap, 0);
    check({tag, "_extra_vend"}, vend_extra, 0);
    check({tag, "_exit_cycle"}, cyc, last + 1);
    check({tag, "_credit_end"}, credit, 0);
    check({tag, "_pulses_idle"}, {two_dime_out, dime_out, nickel_out}, 0);
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    step();
    step();
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {coin_accept, coin_reject, vend_go, two_dime_out, dime_out, nickel_out}, 0);
    check("rst_stocks", {nickel_stock, dime_stock}, 0);
    rst_n = 1'b1;
    step();

    // Underpriced vend is ignored
    insert(DIME);
    check("dime_accept", coin_accept, 1);
    check("dime_credit", credit, 10);
    insert(QUARTER);
    insert(QUARTER);
    check("q2_credit", credit, 60);
    vend();
    check("low_vend_go", vend_go, 0);
    check("low_vend_credit", credit, 60);
    check("low_vend_busy", busy, 0);
    refund();
    run_change("refund60", 0, 3, 0, 0);

    // Vend with one dime of change
    insert(QUARTER);
    insert(QUARTER);
    insert(QUARTER);
    check("q3_credit", credit, 75);
    vend();
    check("vend_go", vend_go, 1);
    check("vend_credit", credit, 10);
    check("vend_busy", busy, 1);
    run_change("vend75", 1, 0, 1, 0);

    // Refund a dollar
    for (int i = 0; i < 4; i++) insert(QUARTER);
    check("q4_credit", credit, 100);
    refund();
    check("ret_first_pulse", two_dime_out, 1);
    check("ret_first_credit", credit, 80);
    run_change("refund100", 0, 5, 0, 0);

    // Overflow, slug and a coin during change
    for (int i = 0; i < 9; i++) insert(QUARTER);
    insert(DIME);
    insert(NICKEL);
    check("credit_240", credit, 240);
    insert(QUARTER);
    check("ovf_reject", coin_reject, 1);
    check("ovf_accept", coin_accept, 0);
    check("ovf_credit", credit, 240);
    insert(SLUG);
    check("slug_reject", coin_reject, 1);
    check("slug_credit", credit, 240);
    refund();
    insert(NICKEL);
    check("chg_coin_reject", coin_reject, 1);
    check("chg_coin_credit", credit, 220);
    check("chg_coin_busy", busy, 1);
    run_change("refund240", 1, 11, 0, 0);
    check("stock_nickel_1", nickel_stock, 1);
    check("stock_dime_2", dime_stock, 2);

    // All three strobes at once: refund wins, coin rejected
    for (int i = 0; i < 3; i++) insert(QUARTER);
    coin_return = 1'b1;
    vend_req    = 1'b1;
    coin_valid  = 1'b1;
    coin_type   = NICKEL;
    step();
    $display("all strobes busy=%0b vend_go=%0b reject=%0b credit=%0d", busy, vend_go, coin_reject, credit);
    check("prio_busy", busy, 1);
    check("prio_vend_go", vend_go, 0);
    check("prio_reject", coin_reject, 1);
    check("prio_accept", coin_accept, 0);
    check("prio_two_dime", two_dime_out, 1);
    check("prio_credit", credit, 55);
    run_change("prio75", 0, 3, 1, 1);

    // Reset in the gap between change pulses
    for (int i = 0; i < 4; i++) insert(QUARTER);
    refund();
    step();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    step();
    $display("reset mid-change busy=%0b credit=%0d", busy, credit);
    check("mid_rst_pulses", {two_dime_out, dime_out, nickel_out, vend_go, coin_accept, coin_reject}, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_credit", credit, 0);
    check("mid_rst_stock", nickel_stock, 0);
    rst_n = 1'b1;
    step();
    step();
    check("post_rst_pulses", {two_dime_out, dime_out, nickel_out, busy}, 0);
    check("post_rst_credit", credit, 0);

    // Nickel stock saturation across vend cycles
    for (int i = 1; i <= 256; i++) begin
      insert(NICKEL);
      if (i == 254) check("stock_254", nickel_stock, 254);
      if (i == 255) check("stock_255", nickel_stock, 255);
      if (i == 256) check("stock_256_hold", nickel_stock, 255);
      if (i % 13 == 0) begin
        check("sat_vend_credit", credit, 65);
        vend();
        check("sat_vend_go", vend_go, 1);
        check("sat_vend_left", credit, 0);
        step();
        check("sat_vend_idle", busy, 0);
      end
    end
    check("sat_tail_credit", credit, 45);
    refund();
    run_change("refund45", 0, 2, 0, 1);
    check("stock_final", nickel_stock, 255);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
